// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants for the sequenced ALU: opcodes, FSM stage encoding,
// flag bit positions and button bit assignments.
package alu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } stage_e;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  // FLAGS is packed {N,V,C,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;

endpackage

// File: rtl/alu_seq_ctrl_core.sv
// Purely combinational ALU: result, {N,V,C,Z} flags and an unsupported-opcode
// error for one operand pair.
module alu_core
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   OP,
  output logic [DATA_W-1:0] RESULT,
  output logic [3:0]        FLAGS,
  output logic              ERR
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic              b_big;
  logic [DATA_W-1:0] srl_res;
  logic [DATA_W-1:0] sra_res;
  logic              carry;
  logic              ovf;

  assign sum_ext  = {1'b0, A} + {1'b0, B};
  // The extra top bit of the difference is the unsigned borrow (A < B).
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign b_big    = (B >= DATA_W'(DATA_W));
  assign srl_res  = b_big ? '0 : (A >> B);
  assign sra_res  = b_big ? {DATA_W{A[MSB]}} : DATA_W'($signed(A) >>> B);

  always_comb begin
    RESULT = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    ERR    = 1'b0;
    case (OP)
      OP_W'(OP_ADD): begin
        RESULT = sum_ext[MSB:0];
        carry  = sum_ext[DATA_W];
        ovf    = (A[MSB] == B[MSB]) && (RESULT[MSB] != A[MSB]);
      end
      OP_W'(OP_SUB): begin
        RESULT = diff_ext[MSB:0];
        carry  = diff_ext[DATA_W];
        ovf    = (A[MSB] != B[MSB]) && (RESULT[MSB] != A[MSB]);
      end
      OP_W'(OP_AND): RESULT = A & B;
      OP_W'(OP_OR):  RESULT = A | B;
      OP_W'(OP_XOR): RESULT = A ^ B;
      OP_W'(OP_NOR): RESULT = ~(A | B);
      OP_W'(OP_SRL): RESULT = srl_res;
      OP_W'(OP_SRA): RESULT = sra_res;
      default:       ERR    = 1'b1;
    endcase
  end

  // An unsupported opcode leaves RESULT at zero, which yields FLAGS = 0001.
  always_comb begin
    FLAGS         = '0;
    FLAGS[FLAG_Z] = (RESULT == '0);
    FLAGS[FLAG_C] = carry;
    FLAGS[FLAG_V] = ovf;
    FLAGS[FLAG_N] = RESULT[MSB];
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Button-sequenced ALU front end: edge-detects the load strobes, walks the
// A -> B -> opcode sequence and registers the ALU result for display.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SWITCHES,
  input  logic [2:0]        BUTTONS,
  output logic [DATA_W-1:0] LEDS,
  output logic [3:0]        FLAGS,
  output logic              VALID,
  output logic              ERR,
  output logic [1:0]        STAGE
);

  stage_e            stage_q, stage_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [2:0]        btn_q, btn_d;
  logic [DATA_W-1:0] leds_q, leds_d;
  logic [3:0]        flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [2:0]        edges;
  logic              single;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              alu_err;

  assign edges  = BUTTONS & ~btn_q;
  assign single = $onehot(edges);

  alu_core #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .A      (a_q),
    .B      (b_q),
    .OP     (SWITCHES[OP_W-1:0]),
    .RESULT (alu_result),
    .FLAGS  (alu_flags),
    .ERR    (alu_err)
  );

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the case
    // can leave a signal unassigned and infer a latch.
    stage_d = stage_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    btn_d   = BUTTONS;
    leds_d  = leds_q;
    flags_d = flags_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (single) begin
      case (stage_q)
        WAIT_A: if (edges[BTN_A]) begin
          a_d     = SWITCHES;
          stage_d = WAIT_B;
        end
        WAIT_B: if (edges[BTN_B]) begin
          b_d     = SWITCHES;
          stage_d = WAIT_OP;
        end
        WAIT_OP: if (edges[BTN_OP]) begin
          op_d    = SWITCHES[OP_W-1:0];
          leds_d  = alu_result;
          flags_d = alu_flags;
          err_d   = alu_err;
          valid_d = 1'b1;
          stage_d = SHOW;
        end
        SHOW: if (edges[BTN_A]) begin
          a_d     = SWITCHES;
          valid_d = 1'b0;
          stage_d = WAIT_B;
        end
        default: stage_d = WAIT_A;
      endcase
    end
  end

  // Reset loads the button history with the live inputs so a held button
  // cannot fire on release of reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (RESET) begin
      stage_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      btn_q   <= BUTTONS;
      leds_q  <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      btn_q   <= btn_d;
      leds_q  <= leds_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign LEDS  = leds_q;
  assign FLAGS = flags_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign STAGE = stage_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl (DATA_W=8): directed corner cases plus
// random button/switch traffic against a behavioural model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [7:0] leds;
  logic [3:0] flags;
  logic       valid;
  logic       err;
  logic [1:0] stage;

  alu_seq_ctrl #(.DATA_W(8), .OP_W(6)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .SWITCHES (sw),
    .BUTTONS  (btn),
    .LEDS     (leds),
    .FLAGS    (flags),
    .VALID    (valid),
    .ERR      (err),
    .STAGE    (stage)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100,
                         T_OR  = 6'b100101, T_XOR = 6'b100110, T_NOR = 6'b100111,
                         T_SRL = 6'b000010, T_SRA = 6'b000011;
  logic [5:0] ops [8];

  typedef struct {
    logic [7:0] leds;
    logic [3:0] flags;
    logic       err;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;

  // Behavioural model state: stage number, captured operands, VALID, last buttons.
  int         m_stage;
  logic [7:0] m_a, m_b;
  logic       m_valid;
  logic [2:0] m_prev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t ref_alu(int a, int b, logic [5:0] op);
    exp_t res;
    int sa = (a >= 128) ? a - 256 : a;
    int sb_v = (b >= 128) ? b - 256 : b;
    int r = 0;
    int s;
    bit c = 0, v = 0, e = 0;
    case (op)
      T_ADD: begin s = a + b; r = s % 256; c = (s > 255);
                   s = sa + sb_v; v = (s > 127) || (s < -128); end
      T_SUB: begin r = (a - b) & 255; c = (a < b);
                   s = sa - sb_v; v = (s > 127) || (s < -128); end
      T_AND: r = a & b;
      T_OR:  r = a | b;
      T_XOR: r = a ^ b;
      T_NOR: r = (~(a | b)) & 255;
      T_SRL: r = (b >= 8) ? 0 : (a >> b);
      T_SRA: r = (b >= 8) ? ((a >= 128) ? 255 : 0) : ((sa >>> b) & 255);
      default: e = 1;
    endcase
    res.leds  = 8'(r);
    res.flags = {(r >= 128), v, c, (r == 0)};
    res.err   = e;
    res.due   = 0;
    return res;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(logic [2:0] b, logic [7:0] s);
    logic [2:0] e;
    exp_t x;
    e = b & ~m_prev;
    m_prev = b;
    if (e == 3'b001 || e == 3'b010 || e == 3'b100) begin
      if (m_stage == 0 && e == 3'b001) begin
        m_a = s; m_stage = 1;
      end else if (m_stage == 1 && e == 3'b010) begin
        m_b = s; m_stage = 2;
      end else if (m_stage == 2 && e == 3'b100) begin
        x = ref_alu(int'(m_a), int'(m_b), s[5:0]);
        x.due = cyc + 1;
        sb.push_back(x);
        m_valid = 1'b1; m_stage = 3;
      end else if (m_stage == 3 && e == 3'b001) begin
        m_a = s; m_valid = 1'b0; m_stage = 1;
      end
    end
  endtask

  task automatic step(logic [2:0] b, logic [7:0] s);
    @(negedge clk);
    btn = b; sw = s;
    model_apply(b, s);
    @(posedge clk); #1;
    check("stage", 32'(stage), 32'(m_stage));
    check("valid", 32'(valid), 32'(m_valid));
  endtask

  task automatic do_reset(logic [2:0] b);
    @(negedge clk);
    rst = 1'b1; btn = b;
    m_stage = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_prev = b;
    @(posedge clk); #1;
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_leds",  32'(leds),  32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic seq(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    step(3'b001, a);
    step(3'b000, a);
    step(3'b010, b);
    step(3'b000, b);
    step(3'b100, {2'b00, op});
  endtask

  task automatic expect_out(string name, logic [7:0] l, logic [3:0] f, logic e);
    check({name, "_leds"},  32'(leds),  32'(l));
    check({name, "_flags"}, 32'(flags), 32'(f));
    check({name, "_err"},   32'(err),   32'(e));
  endtask

  // Monitor: every rising VALID must match the oldest expected result and
  // appear exactly one cycle after the opcode edge was sampled.
  initial begin
    logic valid_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && valid_prev !== 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("sb_leds",    32'(leds),  32'(e.leds));
          check("sb_flags",   32'(flags), 32'(e.flags));
          check("sb_err",     32'(err),   32'(e.err));
          check("sb_latency", 32'(cyc),   32'(e.due));
        end
      end
      valid_prev = valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [2:0] b;
    logic [7:0] s;
    ops = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SRL, T_SRA};
    rst = 1'b1; btn = 3'b000; sw = 8'h00;
    m_stage = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_prev = '0;
    repeat (2) @(posedge clk);
    do_reset(3'b000);

    // Signed overflow on ADD, one-cycle VALID latency.
    seq(8'h7F, 8'h01, T_ADD);
    expect_out("add_ovf", 8'h80, 4'b1100, 1'b0);
    // SUB to zero, then SUB with borrow.
    seq(8'h05, 8'h05, T_SUB);
    expect_out("sub_zero", 8'h00, 4'b0001, 1'b0);
    seq(8'h00, 8'h01, T_SUB);
    expect_out("sub_borrow", 8'hFF, 4'b1010, 1'b0);
    // Shift amounts at and beyond the width.
    seq(8'h80, 8'h09, T_SRA);
    expect_out("sra_big", 8'hFF, 4'b1000, 1'b0);
    seq(8'h80, 8'h09, T_SRL);
    expect_out("srl_big", 8'h00, 4'b0001, 1'b0);
    seq(8'h80, 8'h01, T_SRA);
    expect_out("sra_one", 8'hC0, 4'b1000, 1'b0);
    // Unsupported opcode, then a new A clears VALID.
    seq(8'h12, 8'h34, 6'b111111);
    expect_out("bad_op", 8'h00, 4'b0001, 1'b1);
    step(3'b001, 8'h55);
    check("bad_op_next_stage", 32'(stage), 32'd1);
    check("bad_op_next_valid", 32'(valid), 32'd0);

    // Held A button gives one capture; out-of-order and multi-edge cycles ignored.
    do_reset(3'b000);
    step(3'b001, 8'h11);
    for (int i = 0; i < 4; i++) step(3'b001, 8'h22 + 8'(i));
    check("held_a_stage", 32'(stage), 32'd1);
    step(3'b101, 8'h20);
    step(3'b000, 8'h00);
    step(3'b011, 8'h66);
    check("multi_edge_stage", 32'(stage), 32'd1);
    step(3'b000, 8'h00);
    step(3'b010, 8'h03);
    step(3'b000, 8'h00);
    step(3'b100, {2'b00, T_ADD});
    expect_out("held_a_add", 8'h14, 4'b0000, 1'b0);

    // Reset wins over a simultaneous OP edge in WAIT_OP; held OP then stays silent.
    do_reset(3'b000);
    step(3'b001, 8'h3C);
    step(3'b000, 8'h00);
    step(3'b010, 8'h04);
    step(3'b000, 8'h00);
    check("pre_reset_stage", 32'(stage), 32'd2);
    do_reset(3'b100);
    for (int i = 0; i < 3; i++) step(3'b100, {2'b00, T_ADD});
    check("post_reset_leds", 32'(leds), 32'd0);
    // A button held through reset must not capture A.
    do_reset(3'b001);
    for (int i = 0; i < 3; i++) step(3'b001, 8'h77);
    check("held_through_reset", 32'(stage), 32'd0);
    step(3'b000, 8'h00);

    // Random traffic, biased toward single presses and legal opcodes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(3'($urandom_range(0, 7)));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 3)      b = 3'b000;
        else if (r < 9) b = 3'(1 << (r % 3));
        else            b = 3'($urandom_range(0, 7));
        s = 8'($urandom);
        if (b[2] && $urandom_range(0, 4) != 0) s = {2'b00, ops[$urandom_range(0, 7)]};
        if (b[1] && $urandom_range(0, 3) == 0) s = 8'($urandom_range(0, 10));
        step(b, s);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
